multiport_register_file: RTL

MULTIPORT_REGISTER_FILE -- requirements
Module: multiport_register_file

---
 rtl/multiport_register_file.sv | 98 +++++++++
 1 files changed

// File: rtl/multiport_register_file.sv
// rtl/multiport_register_file.sv - two-read/one-write register file with per-entry busy scoreboard (optional forwarding: RF_BYPASS_EN)
module multiport_register_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int ZERO_REG   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  issue_en,
    input  logic [ADDR_WIDTH-1:0] issue_addr,
    input  logic [ADDR_WIDTH-1:0] rd_addr_a,
    input  logic [ADDR_WIDTH-1:0] rd_addr_b,
    output logic [DATA_WIDTH-1:0] rd_data_a,
    output logic [DATA_WIDTH-1:0] rd_data_b,
    output logic                  rd_busy_a,
    output logic                  rd_busy_b,
    output logic [ADDR_WIDTH:0]   busy_count
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam bit ZR    = (ZERO_REG != 0);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0]      busy_q, busy_d;
    logic [ADDR_WIDTH:0]   busy_count_q, busy_count_d;
    logic                  wr_ok, issue_ok;

    // Writes and issues aimed at a hardwired-zero entry 0 are ignored
    always_comb begin
        wr_ok    = wr_en    && !(ZR && (wr_addr    == '0));
        issue_ok = issue_en && !(ZR && (issue_addr == '0));
    end

    // Next data, busy bits (set beats clear) and the population count of the new busy bits
    always_comb begin
        mem_d  = mem_q;
        busy_d = busy_q;
        if (wr_ok) begin
            mem_d[wr_addr]  = wr_data;
            busy_d[wr_addr] = 1'b0;
        end
        if (issue_ok) begin
            busy_d[issue_addr] = 1'b1;
        end
        busy_count_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            busy_count_d = busy_count_d + (ADDR_WIDTH+1)'(busy_d[i]);
        end
    end

    // State registers, cleared asynchronously while rst is low
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q        <= '{default: '0};
            busy_q       <= '0;
            busy_count_q <= '0;
        end else begin
            mem_q        <= mem_d;
            busy_q       <= busy_d;
            busy_count_q <= busy_count_d;
        end
    end

    // Combinational read port A, optionally forwarding the same-cycle writeback
    always_comb begin
        rd_data_a = (ZR && (rd_addr_a == '0)) ? '0 : mem_q[rd_addr_a];
        rd_busy_a = busy_q[rd_addr_a];
`ifdef RF_BYPASS_EN
        if (wr_ok && (wr_addr == rd_addr_a)) begin
            rd_data_a = wr_data;
            if (!(issue_en && (issue_addr == rd_addr_a))) begin
                rd_busy_a = 1'b0;
            end
        end
`endif
    end

    // Combinational read port B, same rules as port A
    always_comb begin
        rd_data_b = (ZR && (rd_addr_b == '0)) ? '0 : mem_q[rd_addr_b];
        rd_busy_b = busy_q[rd_addr_b];
`ifdef RF_BYPASS_EN
        if (wr_ok && (wr_addr == rd_addr_b)) begin
            rd_data_b = wr_data;
            if (!(issue_en && (issue_addr == rd_addr_b))) begin
                rd_busy_b = 1'b0;
            end
        end
`endif
    end

    assign busy_count = busy_count_q;

endmodule
